// File: rtl/nios_system_nios2_cpu_debug_ocimem_if.sv
// Debug OCI memory bus bundle: JTAG command strobes from the debug slave,
// the CPU-side Avalon-MM slave and the monitor status returned to the debug slave.
interface nios_system_nios2_cpu_debug_ocimem_if #(
    parameter int ADDR_W = 8
);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              debugack;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    modport master (
        output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
               debugack, avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest, MonDReg, monitor_ready, monitor_error
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
               debugack, avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest, MonDReg, monitor_ready, monitor_error
    );
endinterface

// File: rtl/nios_system_nios2_cpu_debug_ocimem.sv
// OCI debug memory: executes JTAG address-load/read/write commands against a private
// RAM and shares that RAM with the CPU over Avalon-MM, JTAG always taking priority.
module nios_system_nios2_cpu_debug_ocimem #(
    parameter int ADDR_W = 8
) (
    input logic                                  clk,
    input logic                                  reset,
    nios_system_nios2_cpu_debug_ocimem_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, J_RD_ISSUE, J_RD_DATA, A_RD_DATA} state_t;
    typedef enum logic [1:0] {P_LOAD, P_LOAD_RD, P_RD_NEXT, P_WRITE} pend_t;

    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_q;
    state_t            r_state;
    logic              r_pend_valid;
    pend_t             r_pend_kind;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [31:0]       r_pend_data;
    logic [ADDR_W-1:0] r_mon_addr;
    logic [31:0]       r_mondreg;
    logic              r_ready;
    logic              r_error;

    logic              w_a, w_na, w_b;
    logic              w_any_strobe, w_multi, w_busy, w_accept, w_drop_err;
    pend_t             w_new_kind;
    logic              w_jwr, w_idle_free, w_avs_wr, w_avs_rd;
    logic              w_we, w_re;
    logic [ADDR_W-1:0] w_waddr, w_raddr;
    logic [31:0]       w_wdata;
    logic [3:0]        w_be;
    logic              w_unused;

    assign w_unused = ^{bus.jdo[37:36], bus.jdo[2:0]};

    assign w_a          = bus.take_action_ocimem_a;
    assign w_na         = bus.take_no_action_ocimem_a;
    assign w_b          = bus.take_action_ocimem_b;
    assign w_any_strobe = w_a || w_na || w_b;
    assign w_multi      = (w_b && (w_a || w_na)) || (w_a && w_na);
    assign w_busy       = r_pend_valid || (r_state != IDLE);
    // Priority b > a > no_action; a blocked b (no debugack) still shadows a lower strobe.
    assign w_accept     = !w_busy && (w_b ? bus.debugack : (w_a || w_na));
    assign w_drop_err   = w_any_strobe && (w_busy || w_multi || (w_b && !bus.debugack));

    always_comb begin
        w_new_kind = P_RD_NEXT;
        if (w_b)      w_new_kind = P_WRITE;
        else if (w_a) w_new_kind = bus.jdo[35] ? P_LOAD_RD : P_LOAD;
    end

    assign w_jwr       = (r_state == IDLE) && r_pend_valid && (r_pend_kind == P_WRITE) && !reset;
    assign w_idle_free = (r_state == IDLE) && !r_pend_valid && !w_any_strobe && !reset;
    assign w_avs_wr    = w_idle_free && bus.avs_write && !bus.avs_read;
    assign w_avs_rd    = w_idle_free && bus.avs_read;

    assign w_we    = w_jwr || w_avs_wr;
    assign w_waddr = w_jwr ? r_mon_addr : bus.avs_address;
    assign w_wdata = w_jwr ? r_pend_data : bus.avs_writedata;
    assign w_be    = w_jwr ? '1 : bus.avs_byteenable;
    assign w_re    = (r_state == J_RD_ISSUE) || w_avs_rd;
    assign w_raddr = (r_state == J_RD_ISSUE) ? r_mon_addr : bus.avs_address;

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)     r_q <= '0;
        else if (w_re) r_q <= r_mem[w_raddr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pend_valid <= 1'b0;
            r_pend_kind  <= P_LOAD;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
            r_mon_addr   <= '0;
            r_mondreg    <= '0;
            r_ready      <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_kind  <= w_new_kind;
                r_pend_addr  <= bus.jdo[17 +: ADDR_W];
                r_pend_data  <= bus.jdo[34:3];
                r_ready      <= 1'b0;
            end
            if (w_drop_err)                  r_error <= 1'b1;
            else if (w_accept && w_a && !w_b) r_error <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_pend_valid) begin
                        r_pend_valid <= 1'b0;
                        case (r_pend_kind)
                            P_LOAD: begin
                                r_mon_addr <= r_pend_addr;
                                r_ready    <= 1'b1;
                            end
                            P_LOAD_RD: begin
                                r_mon_addr <= r_pend_addr;
                                r_state    <= J_RD_ISSUE;
                            end
                            P_RD_NEXT: r_state <= J_RD_ISSUE;
                            P_WRITE: begin
                                r_mon_addr <= r_mon_addr + ADDR_W'(1);
                                r_ready    <= 1'b1;
                            end
                            default: r_state <= IDLE;
                        endcase
                    end else if (w_avs_rd) begin
                        r_state <= A_RD_DATA;
                    end
                end
                J_RD_ISSUE: r_state <= J_RD_DATA;
                J_RD_DATA: begin
                    r_mondreg  <= r_q;
                    r_mon_addr <= r_mon_addr + ADDR_W'(1);
                    r_ready    <= 1'b1;
                    r_state    <= IDLE;
                end
                A_RD_DATA: r_state <= IDLE;
                default:   r_state <= IDLE;
            endcase
        end
    end

    assign bus.avs_readdata    = r_q;
    assign bus.avs_waitrequest = (bus.avs_read || bus.avs_write) &&
                                 !(w_avs_wr || ((r_state == A_RD_DATA) && bus.avs_read));
    assign bus.MonDReg         = r_mondreg;
    assign bus.monitor_ready   = r_ready;
    assign bus.monitor_error   = r_error;
endmodule

// File: tb/tb_nios_system_nios2_cpu_debug_ocimem.sv
// Scoreboard bench for the OCI debug memory: JTAG completions and Avalon read
// returns are checked by a monitor against expectations queued by the stimulus.
module tb_nios_system_nios2_cpu_debug_ocimem;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nios_system_nios2_cpu_debug_ocimem_if #(.ADDR_W(AW)) bus ();

    nios_system_nios2_cpu_debug_ocimem #(.ADDR_W(AW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        string       name;
        logic [31:0] mond;
        logic        err;
        int          t0;
        int          lat;
    } jexp_t;
    typedef struct {
        string       name;
        logic [31:0] data;
    } aexp_t;

    jexp_t jq[$];
    aexp_t aq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
        logic [37:0] j;
        j = '0;
        j[17 +: 8] = addr;
        j[35] = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] j;
        j = '0;
        j[34:3] = data;
        return j;
    endfunction

    // Monitor: JTAG completion = rising monitor_ready; Avalon return = read accepted.
    logic  prev_rdy = 1'b0;
    jexp_t je;
    aexp_t ae;
    always @(negedge clk) begin
        if (bus.monitor_ready && !prev_rdy) begin
            if (jq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL jtag_unexpected_ready actual=1 expected=0 MonDReg=0x%08h", bus.MonDReg);
            end else begin
                je = jq.pop_front();
                check({je.name, "_mondreg"}, bus.MonDReg, je.mond);
                check({je.name, "_err"}, {31'b0, bus.monitor_error}, {31'b0, je.err});
                check({je.name, "_latency"}, 32'(cyc - je.t0), 32'(je.lat));
            end
        end
        prev_rdy = bus.monitor_ready;
        if (bus.avs_read && !bus.avs_waitrequest) begin
            if (aq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL avs_unexpected_read actual=0x%08h expected=none", bus.avs_readdata);
            end else begin
                ae = aq.pop_front();
                check({ae.name, "_rdata"}, bus.avs_readdata, ae.data);
            end
        end
    end

    task automatic wait_jq;
        for (int i = 0; i < 40 && jq.size() != 0; i++) tick;
        if (jq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL jtag_timeout actual_pending=%0d expected=0", jq.size());
            jq.delete();
        end
    endtask

    task automatic jtag(input logic a, input logic na, input logic b, input logic [37:0] j,
                        input logic evt, input string name, input logic [31:0] mond,
                        input logic err, input int lat);
        tick;
        if (evt) jq.push_back('{name, mond, err, cyc, lat});
        bus.jdo = j;
        bus.take_action_ocimem_a = a;
        bus.take_no_action_ocimem_a = na;
        bus.take_action_ocimem_b = b;
        tick;
        bus.take_action_ocimem_a = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b = 1'b0;
        wait_jq;
    endtask

    task automatic avs(input logic rd, input logic wr, input logic [7:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input int exp_waits, input string name, input logic [31:0] exp_rd);
        int   waits;
        logic done;
        waits = 0;
        done = 1'b0;
        tick;
        if (rd) aq.push_back('{name, exp_rd});
        bus.avs_address = addr;
        bus.avs_writedata = wdata;
        bus.avs_byteenable = be;
        bus.avs_read = rd;
        bus.avs_write = wr;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!bus.avs_waitrequest) done = 1'b1;
            else waits++;
            @(posedge clk);
            #1;
        end
        bus.avs_read = 1'b0;
        bus.avs_write = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=waitrequest_stuck expected=served", name);
            aq.delete();
        end else begin
            check({name, "_waits"}, 32'(waits), 32'(exp_waits));
        end
    endtask

    initial begin
        bus.jdo = '0;
        bus.take_action_ocimem_a = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b = 1'b0;
        bus.debugack = 1'b0;
        bus.avs_address = '0;
        bus.avs_read = 1'b0;
        bus.avs_write = 1'b0;
        bus.avs_writedata = '0;
        bus.avs_byteenable = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_mondreg", bus.MonDReg, 32'h0);
        check("rst_ready", {31'b0, bus.monitor_ready}, 32'h0);
        check("rst_error", {31'b0, bus.monitor_error}, 32'h0);
        check("rst_readdata", bus.avs_readdata, 32'h0);
        check("rst_waitreq", {31'b0, bus.avs_waitrequest}, 32'h0);

        // Address load, then prove MonAReg=0x10 by writing there and reading via Avalon.
        jtag(1, 0, 0, jdo_a(8'h10, 0), 1, "ld10", 32'h0, 0, 2);
        bus.debugack = 1'b1;
        jtag(0, 0, 1, jdo_b(32'h0000_1010), 1, "wr10", 32'h0, 0, 2);
        avs(1, 0, 8'h10, '0, '0, 1, "ard10", 32'h0000_1010);

        jtag(1, 0, 0, jdo_a(8'h20, 0), 1, "ld20", 32'h0, 0, 2);
        jtag(0, 0, 1, jdo_b(32'hDEAD_BEEF), 1, "wr20", 32'h0, 0, 2);
        jtag(0, 0, 1, jdo_b(32'h1234_5678), 1, "wr21", 32'h0, 0, 2);
        jtag(1, 0, 0, jdo_a(8'h20, 1), 1, "rd20", 32'hDEAD_BEEF, 0, 4);
        jtag(0, 1, 0, '0, 1, "rdnext21", 32'h1234_5678, 0, 4);
        jtag(0, 0, 1, jdo_b(32'h2222_2222), 1, "wr22", 32'h1234_5678, 0, 2);
        avs(1, 0, 8'h22, '0, '0, 1, "ard22", 32'h2222_2222);

        // Address wrap at the top of the RAM.
        avs(0, 1, 8'h00, 32'h0BAD_F00D, 4'hF, 0, "awr00", '0);
        jtag(1, 0, 0, jdo_a(8'hFF, 0), 1, "ldFF", 32'h1234_5678, 0, 2);
        jtag(0, 0, 1, jdo_b(32'hA5A5_A5A5), 1, "wrFF", 32'h1234_5678, 0, 2);
        jtag(0, 1, 0, '0, 1, "rdwrap00", 32'h0BAD_F00D, 0, 4);
        jtag(0, 0, 1, jdo_b(32'h0101_0101), 1, "wr01", 32'h0BAD_F00D, 0, 2);
        avs(1, 0, 8'hFF, '0, '0, 1, "ardFF", 32'hA5A5_A5A5);
        avs(1, 0, 8'h01, '0, '0, 1, "ard01", 32'h0101_0101);

        // Write without debugack is dropped; a clears the error; b+a together runs b.
        avs(0, 1, 8'h02, 32'h0202_0202, 4'hF, 0, "awr02", '0);
        bus.debugack = 1'b0;
        jtag(0, 0, 1, jdo_b(32'h9999_9999), 0, "", '0, 0, 0);
        tick;
        @(negedge clk);
        check("nodbg_error", {31'b0, bus.monitor_error}, 32'h1);
        avs(1, 0, 8'h02, '0, '0, 1, "ard02", 32'h0202_0202);
        jtag(1, 0, 0, jdo_a(8'h30, 0), 1, "ld30clr", 32'h0BAD_F00D, 0, 2);
        bus.debugack = 1'b1;
        jtag(1, 0, 1, jdo_b(32'h7777_7777), 1, "ba_wr30", 32'h0BAD_F00D, 1, 2);
        avs(1, 0, 8'h30, '0, '0, 1, "ard30", 32'h7777_7777);

        // Byte-enabled Avalon write.
        avs(0, 1, 8'h05, 32'h1122_3344, 4'hF, 0, "awr05", '0);
        avs(0, 1, 8'h05, 32'hCAFE_F00D, 4'b0011, 0, "awr05be", '0);
        avs(1, 0, 8'h05, '0, '0, 1, "ard05", 32'h1122_F00D);

        // JTAG read and Avalon read in the same cycle: JTAG first, Avalon stalls 5 cycles.
        fork
            jtag(1, 0, 0, jdo_a(8'h20, 1), 1, "rd20conc", 32'hDEAD_BEEF, 0, 4);
            avs(1, 0, 8'h05, '0, '0, 5, "ard05conc", 32'h1122_F00D);
        join

        // Reset while the JTAG read is in J_RD_ISSUE.
        tick;
        bus.jdo = jdo_a(8'h20, 1);
        bus.take_action_ocimem_a = 1'b1;
        tick;
        bus.take_action_ocimem_a = 1'b0;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_mondreg", bus.MonDReg, 32'h0);
        check("midrst_ready", {31'b0, bus.monitor_ready}, 32'h0);
        check("midrst_error", {31'b0, bus.monitor_error}, 32'h0);
        repeat (5) tick;
        @(negedge clk);
        check("midrst_ready_late", {31'b0, bus.monitor_ready}, 32'h0);
        avs(1, 0, 8'h05, '0, '0, 1, "ard05rst", 32'h1122_F00D);

        repeat (3) tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/nios_system_nios2_cpu_debug_ocimem.md
Name: nios_system_nios2_cpu_debug_ocimem

Overview:
On-chip-instrumentation memory controller sitting directly downstream of the CPU debug slave wrapper in the clk domain. Consumes jdo and the take_action_ocimem_a/b / take_no_action_ocimem_a strobes, executes JTAG address-load, read and write commands against a private debug RAM, and returns MonDReg/monitor_ready/monitor_error to the debug slave. Also exposes the same RAM to the CPU through an Avalon-MM slave, with JTAG given priority.

Parameters:
ADDR_W, 8, debug RAM word-address width; depth = 2^ADDR_W words of 32 bits.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
jdo  in  38  JTAG data/command word from debug slave, valid in strobe cycle.
take_action_ocimem_a  in  1  1-cycle strobe: address load, optional read.
take_no_action_ocimem_a  in  1  1-cycle strobe: read at current address, post-increment.
take_action_ocimem_b  in  1  1-cycle strobe: write at current address, post-increment.
debugack  in  1  CPU is in debug mode; JTAG writes permitted only when 1.
avs_address  in  ADDR_W  CPU word address.
avs_read  in  1  CPU read request.
avs_write  in  1  CPU write request.
avs_writedata  in  32  CPU write data.
avs_byteenable  in  4  CPU byte enables (writes only).
avs_readdata  out  32  CPU read data, valid when avs_read=1 and avs_waitrequest=0.
avs_waitrequest  out  1  Avalon stall.
MonDReg  out  32  last JTAG read data.
monitor_ready  out  1  last JTAG command complete.
monitor_error  out  1  sticky: JTAG command dropped.

Behaviour:
- Reset: MonDReg=0, MonAReg (internal address)=0, monitor_ready=0, monitor_error=0, pending cleared, state IDLE, avs_readdata=0. RAM contents not reset. Reset mid-operation discards the pending/in-flight command; no RAM write occurs in the reset cycle.
- Strobe capture: one-entry pending register. Simultaneous strobes: priority b > a > no_action_a; lower-priority strobes dropped, monitor_error<=1.
- Strobe while pending valid or state != IDLE: dropped, monitor_error<=1.
- Accepted strobe: monitor_ready<=0 next cycle.
- Decode: a: addr=jdo[17 +: ADDR_W], read if jdo[35]=1. a also clears monitor_error. b: data=jdo[34:3]. If b strobe has debugack=0, it is dropped and monitor_error<=1.
- FSM states: IDLE, J_RD_ISSUE, J_RD_DATA, A_RD_DATA.
- IDLE, pending address-load without read: MonAReg<=addr, monitor_ready<=1, stay IDLE.
- IDLE, pending read (a with read, or no_action_a): a loads MonAReg first, then J_RD_ISSUE presents MonAReg to RAM, then J_RD_DATA. For a, the read uses the newly loaded address.
- J_RD_DATA: MonDReg<=RAM q, MonAReg<=MonAReg+1 (mod 2^ADDR_W, wraps to 0), monitor_ready<=1, go to IDLE.
- IDLE, pending write: RAM[MonAReg]<=data (all bytes), MonAReg+1 with wrap, monitor_ready<=1, same cycle, stay IDLE.
- Latency from strobe to monitor_ready=1: write/address-load 2 cycles; read 4 cycles (capture, issue, data, flag).
- Avalon arbitration: JTAG always wins. Avalon is served only in IDLE with no pending command and no strobe that cycle.
- avs_write: single cycle, waitrequest=0 when served; byte-enabled write.
- avs_read: waitrequest=1 in the issue cycle; the FSM goes to A_RD_DATA, where waitrequest=0 and avs_readdata=q.
- Not served: waitrequest=1 whenever avs_read or avs_write is asserted.
- avs_read and avs_write asserted together: read served, write stalled.
- A_RD_DATA always returns to IDLE. A JTAG strobe arriving in A_RD_DATA is dropped with error; the debug host retries on !monitor_ready.

Test Plan:
- Reset, then a with jdo[35]=0, addr=0x10 -> after 2 cycles monitor_ready=1, MonAReg=0x10, MonDReg=0, no RAM access.
- debugack=1; a addr=0x20; b data 0xDEADBEEF; b data 0x12345678; a addr=0x20 read -> MonDReg=0xDEADBEEF. Then no_action_a -> MonDReg=0x12345678, MonAddr ends at 0x22.
- Address wrap: a addr=0xFF, b write 0xA5A5A5A5, then no_action_a -> reads RAM[0x00]. MonAReg post-increments to 0x00 after the write, then 0x01 after the read.
- b with debugack=0 -> RAM unchanged, monitor_error=1. Next a strobe clears it. Also b and a in the same cycle -> b executed, monitor_error=1.
- Avalon write 0xCAFEF00D byte-enable 0b0011 to 0x05 over 0x11223344 -> then read returns 0x1122F00D with waitrequest high exactly 1 cycle.
- avs_read asserted in the same cycle as a with jdo[35]=1 -> JTAG read completes first, waitrequest held until IDLE is free. Reset asserted during J_RD_ISSUE -> monitor_ready=0, MonDReg=0, Avalon read then completes normally.
